// File: rtl/rob_commit_ctrl.sv
//==============================================================================
// rob_commit_ctrl
// Reorder-buffer sequencing: in-order tag allocation, out-of-order completion,
// and in-order commit over a valid/ready handshake.
// Revision: 1.0
//==============================================================================
`default_nettype none

module rob_commit_ctrl #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alloc_req,
    output logic                  alloc_ready,
    output logic [ADDR_WIDTH-1:0] alloc_tag,
    input  logic                  complete_valid,
    input  logic [ADDR_WIDTH-1:0] complete_tag,
    output logic                  commit_valid,
    output logic [ADDR_WIDTH-1:0] commit_tag,
    input  logic                  commit_ready,
    input  logic                  flush,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] head_q, head_d;
    logic [ADDR_WIDTH-1:0] tail_q, tail_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [DEPTH-1:0]      done_q, done_d;

    logic alloc_fire;
    logic commit_fire;

    assign full         = (count_q == C_DEPTH);
    assign empty        = (count_q == '0);
    assign count        = count_q;
    assign alloc_ready  = ~full;
    assign alloc_tag    = tail_q;
    assign commit_tag   = head_q;
    assign commit_valid = valid_q[head_q] & done_q[head_q];

    assign alloc_fire  = alloc_req & ~full;
    assign commit_fire = commit_valid & commit_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        done_d  = done_q;

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = '0;
            done_d  = '0;
        end else begin
            if (complete_valid && valid_q[complete_tag]) begin
                done_d[complete_tag] = 1'b1;
            end
            // Commit clear is applied after completion so it wins on the head entry.
            if (commit_fire) begin
                valid_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
                head_d          = head_q + 1'b1;
            end
            if (alloc_fire) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                tail_d          = tail_q + 1'b1;
            end
            count_d = count_q + (ADDR_WIDTH+1)'(alloc_fire)
                              - (ADDR_WIDTH+1)'(commit_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rob_commit_ctrl.sv
//==============================================================================
// tb_rob_commit_ctrl
// Directed vectors, corner-case sequences and random traffic against a queue model.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_rob_commit_ctrl;

    logic       clk = 1'b0;
    logic       reset, alloc_req, complete_valid, commit_ready, flush;
    logic [3:0] complete_tag;
    logic       alloc_ready, commit_valid, empty, full;
    logic [3:0] alloc_tag, commit_tag;
    logic [4:0] count;

    int total = 0;
    int bad   = 0;

    // Model: occupied entries are the 'm_size' tags starting at m_head.
    int m_head = 0;
    int m_size = 0;
    bit m_done [16];
    bit known  = 1'b0;

    typedef struct {
        logic       rq;
        logic       cv;
        logic [3:0] ct;
        logic       cr;
        int         e_count;
        int         e_atag;
        int         e_cv;
        int         e_ctag;
        int         e_empty;
        int         e_full;
    } vec_t;

    vec_t tbl [9];

    rob_commit_ctrl #(.ADDR_WIDTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .alloc_req      (alloc_req),
        .alloc_ready    (alloc_ready),
        .alloc_tag      (alloc_tag),
        .complete_valid (complete_valid),
        .complete_tag   (complete_tag),
        .commit_valid   (commit_valid),
        .commit_tag     (commit_tag),
        .commit_ready   (commit_ready),
        .flush          (flush),
        .empty          (empty),
        .full           (full),
        .count          (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("m_count",   32'(count),        32'(m_size));
        chk("m_empty",   32'(empty),        32'(m_size == 0));
        chk("m_full",    32'(full),         32'(m_size == 16));
        chk("m_aready",  32'(alloc_ready),  32'(m_size != 16));
        chk("m_atag",    32'(alloc_tag),    32'((m_head + m_size) % 16));
        chk("m_ctag",    32'(commit_tag),   32'(m_head));
        chk("m_cvalid",  32'(commit_valid), 32'(m_size > 0 && m_done[m_head]));
    endtask

    task automatic model_step(input logic rq, cv, input logic [3:0] ct, input logic cr, fl, rs);
        int tail;
        bit af, cf;
        if (rs || fl) begin
            m_head = 0;
            m_size = 0;
            foreach (m_done[i]) m_done[i] = 1'b0;
            known  = 1'b1;
        end else if (known) begin
            tail = (m_head + m_size) % 16;
            af   = rq && (m_size < 16);
            cf   = cr && (m_size > 0) && m_done[m_head];
            if (cv && (((int'(ct) - m_head + 16) % 16) < m_size)) m_done[ct] = 1'b1;
            if (cf) begin
                m_done[m_head] = 1'b0;
                m_head = (m_head + 1) % 16;
                m_size--;
            end
            if (af) begin
                m_done[tail] = 1'b0;
                m_size++;
            end
        end
    endtask

    // Drive one cycle: inputs at negedge, model compare, then advance past posedge.
    task automatic cyc(input logic rq, cv, input logic [3:0] ct, input logic cr, fl, rs);
        @(negedge clk);
        alloc_req      = rq;
        complete_valid = cv;
        complete_tag   = ct;
        commit_ready   = cr;
        flush          = fl;
        reset          = rs;
        if (known) check_model();
        @(posedge clk);
        model_step(rq, cv, ct, cr, fl, rs);
        #2;
    endtask

    task automatic do_reset();
        cyc(0, 0, 4'd0, 0, 0, 1);
        cyc(0, 0, 4'd0, 0, 0, 0);
    endtask

    initial begin
        tbl[0] = '{1, 0, 4'd0, 0, 1, 1, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 4'd0, 0, 2, 2, 0, 0, 0, 0};
        tbl[2] = '{1, 0, 4'd0, 0, 3, 3, 0, 0, 0, 0};
        tbl[3] = '{0, 1, 4'd2, 1, 3, 3, 0, 0, 0, 0};
        tbl[4] = '{0, 1, 4'd1, 1, 3, 3, 0, 0, 0, 0};
        tbl[5] = '{0, 1, 4'd0, 1, 3, 3, 1, 0, 0, 0};
        tbl[6] = '{0, 0, 4'd0, 1, 2, 3, 1, 1, 0, 0};
        tbl[7] = '{0, 0, 4'd0, 1, 1, 3, 1, 2, 0, 0};
        tbl[8] = '{0, 0, 4'd0, 1, 0, 3, 0, 3, 1, 0};

        reset = 1'b1; flush = 1'b0; alloc_req = 1'b0;
        complete_valid = 1'b0; complete_tag = '0; commit_ready = 1'b0;

        // Reset state
        do_reset();
        chk("rst_empty",  32'(empty),        32'd1);
        chk("rst_full",   32'(full),         32'd0);
        chk("rst_aready", 32'(alloc_ready),  32'd1);
        chk("rst_atag",   32'(alloc_tag),    32'd0);
        chk("rst_cvalid", 32'(commit_valid), 32'd0);
        chk("rst_ctag",   32'(commit_tag),   32'd0);
        chk("rst_count",  32'(count),        32'd0);

        // Allocate 3, complete out of order, commit in order
        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].rq, tbl[i].cv, tbl[i].ct, tbl[i].cr, 0, 0);
            chk($sformatf("v%0d_count", i),  32'(count),        32'(tbl[i].e_count));
            chk($sformatf("v%0d_atag", i),   32'(alloc_tag),    32'(tbl[i].e_atag));
            chk($sformatf("v%0d_cvalid", i), 32'(commit_valid), 32'(tbl[i].e_cv));
            chk($sformatf("v%0d_ctag", i),   32'(commit_tag),   32'(tbl[i].e_ctag));
            chk($sformatf("v%0d_empty", i),  32'(empty),        32'(tbl[i].e_empty));
            chk($sformatf("v%0d_full", i),   32'(full),         32'(tbl[i].e_full));
        end

        // Fill to 16; alloc blocked while full even with a same-cycle commit
        do_reset();
        for (int i = 0; i < 16; i++) cyc(1, 0, 4'd0, 0, 0, 0);
        chk("full_full",   32'(full),        32'd1);
        chk("full_aready", 32'(alloc_ready), 32'd0);
        chk("full_count",  32'(count),       32'd16);
        cyc(0, 1, 4'd0, 0, 0, 0);
        cyc(1, 0, 4'd0, 1, 0, 0);
        chk("full_commit_count", 32'(count),     32'd15);
        chk("full_commit_atag",  32'(alloc_tag), 32'd0);
        chk("full_commit_ctag",  32'(commit_tag), 32'd1);

        // Steady state alloc+complete+commit, wrapping pointers
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 1, 4'((i + 15) % 16), 0, 0, 0);
        cyc(0, 1, 4'd2, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 4'(alloc_tag - 4'd1), 1, 0, 0);
            chk("steady_count", 32'(count),      32'd3);
            chk("steady_ctag",  32'(commit_tag), 32'((i + 1) % 16));
        end

        // Completion to an invalid entry is dropped
        do_reset();
        cyc(0, 1, 4'd9, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(1, 0, 4'd0, 0, 0, 0);
        for (int i = 0; i < 9; i++) cyc(0, 1, 4'(i), 1, 0, 0);
        cyc(0, 0, 4'd0, 1, 0, 0);
        cyc(0, 0, 4'd0, 1, 0, 0);
        chk("inv_ctag",   32'(commit_tag),   32'd9);
        chk("inv_cvalid", 32'(commit_valid), 32'd0);
        chk("inv_count",  32'(count),        32'd1);

        // Flush with every input asserted
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 0, 4'd0, 0, 0, 0);
        cyc(0, 1, 4'd0, 0, 0, 0);
        cyc(1, 1, 4'd1, 1, 1, 0);
        chk("flush_count",  32'(count),        32'd0);
        chk("flush_empty",  32'(empty),        32'd1);
        chk("flush_cvalid", 32'(commit_valid), 32'd0);
        chk("flush_atag",   32'(alloc_tag),    32'd0);
        chk("flush_ctag",   32'(commit_tag),   32'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc(logic'($urandom_range(0, 9) < 7),
                logic'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)),
                logic'($urandom_range(0, 3) != 0),
                logic'($urandom_range(0, 99) < 2),
                logic'($urandom_range(0, 199) == 0));
        end
        cyc(0, 0, 4'd0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
